// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, bus register map and
// status-register bit positions.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  localparam int STAT_RDA = 0;
  localparam int STAT_FE  = 1;
  localparam int STAT_OE  = 2;

endpackage : spart_pkg

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for the asynchronous RxD line; resets to the idle
// (high) level so a reset never looks like a start bit.
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from before the edge and form a true 2-stage chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : spart_sync2

// File: rtl/spart_receive.sv
// SPART receive half: oversampled 8N1 frame recovery on the shared baud tick,
// with a one-byte holding register and RDA/FE/OE status readable over IOADDR.
module spart_receive
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MID        = OVERSAMPLE / 2 - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       Enable,
  input  logic       IORW,
  input  logic [1:0] IOADDR,
  output logic [7:0] DATA_OUT,
  output logic       RDA
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID);

  logic            rxd_s;
  rx_state_t       state, state_nxt;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      rx_data;
  logic            fe, oe;
  logic            frame_ok, frame_fe;
  logic            rd_data, rd_status;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxd_s)
  );

  assign rd_data   = IORW && (IOADDR == ADDR_DATA);
  assign rd_status = IORW && (IOADDR == ADDR_STATUS);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    frame_ok  = 1'b0;
    frame_fe  = 1'b0;
    if (Enable) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            // Line still low at mid-bit: a real start bit, else a glitch.
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_nxt = {rxd_s, shift[7:1]};
            bit_nxt   = bit_cnt + 1'b1;
            tick_nxt  = '0;
            if (bit_cnt == 3'd7) state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            bit_nxt  = '0;
            if (rxd_s) begin
              frame_ok  = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_fe  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          bit_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
    end
  end

  // Setting a flag takes priority over the read that would clear it, so a
  // completion or error on the same edge as a read is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
      RDA     <= 1'b0;
      fe      <= 1'b0;
      oe      <= 1'b0;
    end else begin
      if (frame_ok) rx_data <= shift;

      if (frame_ok)     RDA <= 1'b1;
      else if (rd_data) RDA <= 1'b0;

      if (frame_ok && RDA && !rd_data) oe <= 1'b1;
      else if (rd_status)              oe <= 1'b0;

      if (frame_fe)       fe <= 1'b1;
      else if (rd_status) fe <= 1'b0;
    end
  end

  always_comb begin
    DATA_OUT = 8'h00;
    if (rd_data) begin
      DATA_OUT = rx_data;
    end else if (rd_status) begin
      DATA_OUT[STAT_RDA] = RDA;
      DATA_OUT[STAT_FE]  = fe;
      DATA_OUT[STAT_OE]  = oe;
    end
  end

endmodule : spart_receive

// File: tb/tb_spart_receive.sv
// Self-checking bench for spart_receive: directed 8N1 frames at several baud
// tick rates, register decode table, overrun, framing error, glitch, reset.
module tb_spart_receive;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       Enable;
  logic       IORW;
  logic [1:0] IOADDR;
  logic [7:0] DATA_OUT;
  logic       RDA;

  int div = 1;
  int checks = 0;
  int errors = 0;

  spart_receive dut (
    .clk      (clk),
    .rst      (rst),
    .RxD      (RxD),
    .Enable   (Enable),
    .IORW     (IORW),
    .IOADDR   (IOADDR),
    .DATA_OUT (DATA_OUT),
    .RDA      (RDA)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk-wide pulse every div clocks (div=1 holds it high).
  initial begin
    int en_cnt;
    en_cnt = 0;
    Enable = 1'b0;
    forever begin
      @(negedge clk);
      en_cnt++;
      if (en_cnt >= div) begin
        en_cnt = 0;
        Enable = 1'b1;
      end else begin
        Enable = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic bit_time(input int n);
    repeat (n * 16 * div) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      bit_time(1);
    end
    RxD = stop;
    bit_time(1);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic rw, output logic [7:0] d);
    @(negedge clk);
    IORW   = rw;
    IOADDR = a;
    #1 d = DATA_OUT;
    @(negedge clk);
    IORW   = 1'b0;
    IOADDR = 2'b00;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, 1'b1, d);
    check(name, d, exp);
  endtask

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] exp_dout;
    logic       exp_rda;
  } dec_vec_t;

  typedef struct {
    int         div;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [7:0] exp_status_after;
  } frame_vec_t;

  dec_vec_t   dec_tab[6];
  frame_vec_t frame_tab[4];

  initial begin
    logic [7:0] d;
    int lat;

    // Decode table applied while 0xA5 is held with RDA=1.
    dec_tab[0] = '{1'b0, 2'b00, 8'h00, 1'b1};
    dec_tab[1] = '{1'b0, 2'b01, 8'h00, 1'b1};
    dec_tab[2] = '{1'b1, 2'b10, 8'h00, 1'b1};
    dec_tab[3] = '{1'b1, 2'b11, 8'h00, 1'b1};
    dec_tab[4] = '{1'b1, 2'b01, 8'h01, 1'b1};
    dec_tab[5] = '{1'b1, 2'b00, 8'hA5, 1'b0};

    frame_tab[0] = '{4, 8'h00, 8'h00, 8'h00};
    frame_tab[1] = '{4, 8'hFF, 8'hFF, 8'h00};
    frame_tab[2] = '{1, 8'hC3, 8'hC3, 8'h00};
    frame_tab[3] = '{2, 8'h81, 8'h81, 8'h00};

    rst    = 1'b1;
    RxD    = 1'b1;
    IORW   = 1'b0;
    IOADDR = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_rda", {7'b0, RDA}, 8'h00);
    read_check("reset_data", ADDR_DATA, 8'h00);
    read_check("reset_status", ADDR_STATUS, 8'h00);

    // 0xA5 at one tick per clk, measuring start-edge-to-RDA latency.
    div = 1;
    bit_time(1);
    lat = -1;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        @(negedge clk);
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk);
          #1;
          if (RDA) begin
            lat = n;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < 150 || lat > 160) begin
      errors++;
      $display("FAIL rda_latency: got %0d clk, expected 150..160 clk", lat);
    end

    foreach (dec_tab[i]) begin
      bus_read(dec_tab[i].addr, dec_tab[i].rw, d);
      check($sformatf("decode_dout[%0d]", i), d, dec_tab[i].exp_dout);
      check($sformatf("decode_rda[%0d]", i), {7'b0, RDA}, {7'b0, dec_tab[i].exp_rda});
    end
    read_check("a5_status_after_read", ADDR_STATUS, 8'h00);

    foreach (frame_tab[i]) begin
      div = frame_tab[i].div;
      send_byte(frame_tab[i].data, 1'b1);
      check($sformatf("frame_rda[%0d]", i), {7'b0, RDA}, 8'h01);
      read_check($sformatf("frame_data[%0d]", i), ADDR_DATA, frame_tab[i].exp_data);
      read_check($sformatf("frame_status[%0d]", i), ADDR_STATUS, frame_tab[i].exp_status_after);
    end

    // Overrun: two frames with no read in between.
    div = 1;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    bit_time(1);
    read_check("overrun_status", ADDR_STATUS, 8'h05);
    read_check("overrun_status2", ADDR_STATUS, 8'h01);
    read_check("overrun_data", ADDR_DATA, 8'h5A);
    read_check("overrun_status3", ADDR_STATUS, 8'h00);

    // Framing error followed by a long break, then a clean frame.
    send_byte(8'h55, 1'b0);
    bit_time(1);
    read_check("fe_status", ADDR_STATUS, 8'h02);
    bit_time(38);
    check("break_rda", {7'b0, RDA}, 8'h00);
    read_check("break_status", ADDR_STATUS, 8'h00);
    RxD = 1'b1;
    bit_time(2);
    send_byte(8'h11, 1'b1);
    check("post_break_rda", {7'b0, RDA}, 8'h01);
    read_check("post_break_data", ADDR_DATA, 8'h11);
    read_check("post_break_status", ADDR_STATUS, 8'h00);

    // 3-tick low glitch must be rejected at the mid-bit check.
    @(negedge clk);
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    bit_time(3);
    check("glitch_rda", {7'b0, RDA}, 8'h00);
    read_check("glitch_status", ADDR_STATUS, 8'h00);
    send_byte(8'h96, 1'b1);
    check("post_glitch_rda", {7'b0, RDA}, 8'h01);

    // Reset after the 4th data bit; 0x96 stays unread so reset must clear it.
    @(negedge clk);
    RxD = 1'b0;
    bit_time(5);
    rst    = 1'b1;
    RxD    = 1'b1;
    IORW   = 1'b1;
    IOADDR = ADDR_DATA;
    #1;
    check("midrst_data", DATA_OUT, 8'h00);
    check("midrst_rda", {7'b0, RDA}, 8'h00);
    IOADDR = ADDR_STATUS;
    #1;
    check("midrst_status", DATA_OUT, 8'h00);
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    IORW = 1'b0;
    bit_time(2);
    send_byte(8'h7E, 1'b1);
    check("post_rst_rda", {7'b0, RDA}, 8'h01);
    read_check("post_rst_data", ADDR_DATA, 8'h7E);
    read_check("post_rst_status", ADDR_STATUS, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spart_receive
